// File: rtl/wb_arbiter.sv
// Two-master Wishbone round-robin arbiter onto one shared bus.
// Optional ack timeout enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
    parameter int AddrW         = 4,
    parameter int DataW         = 8,
    parameter int TimeoutCycles = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_wb_we_i,
    input  logic [AddrW-1:0] m0_wb_adr_i,
    input  logic [DataW-1:0] m0_wb_dat_i,
    input  logic             m0_wb_stb_i,
    output logic [DataW-1:0] m0_wb_dat_o,
    output logic             m0_wb_ack_o,
    input  logic             m1_wb_we_i,
    input  logic [AddrW-1:0] m1_wb_adr_i,
    input  logic [DataW-1:0] m1_wb_dat_i,
    input  logic             m1_wb_stb_i,
    output logic [DataW-1:0] m1_wb_dat_o,
    output logic             m1_wb_ack_o,
    output logic             s_wb_we_o,
    output logic [AddrW-1:0] s_wb_adr_o,
    output logic [DataW-1:0] s_wb_dat_o,
    output logic             s_wb_stb_o,
    input  logic [DataW-1:0] s_wb_dat_i,
    input  logic             s_wb_ack_i,
    output logic [1:0]       grant_o,
    output logic             timeout_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);

    state_t     state_reg, state_next;
    logic [1:0] grant_reg, grant_next;
    logic       last_reg, last_next;   // 1: m1 was served last

    logic             busy;
    logic             sel;
    logic             g_stb;
    logic             g_we;
    logic [AddrW-1:0] g_adr;
    logic [DataW-1:0] g_dat;
    logic             done_ack;
    logic             expire;
    logic [1:0]       m_ack;
    logic [DataW-1:0] m_dat [2];

    assign busy  = (state_reg == BUSY);
    assign sel   = grant_reg[1];
    assign g_stb = sel ? m1_wb_stb_i : m0_wb_stb_i;
    assign g_we  = sel ? m1_wb_we_i  : m0_wb_we_i;
    assign g_adr = sel ? m1_wb_adr_i : m0_wb_adr_i;
    assign g_dat = sel ? m1_wb_dat_i : m0_wb_dat_i;

    // A dropped strobe is an abort, so an ack in that cycle is not delivered.
    assign done_ack = busy & g_stb & s_wb_ack_i;

`ifdef WB_ARBITER_TIMEOUT_EN
    logic [15:0] cnt_reg;
    logic        tflag_reg;

    assign expire    = busy & g_stb & ~s_wb_ack_i & (cnt_reg == CntLast);
    assign timeout_o = tflag_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg   <= '0;
            tflag_reg <= 1'b0;
        end else begin
            if (!busy) begin
                cnt_reg <= '0;
            end else if (!s_wb_ack_i) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
            if (expire) begin
                tflag_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign expire         = 1'b0;
    assign timeout_o      = 1'b0;
    assign unused_timeout = ^CntLast;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            grant_reg <= 2'b00;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (m0_wb_stb_i || m1_wb_stb_i) begin
                    state_next = BUSY;
                    if (m0_wb_stb_i && m1_wb_stb_i) begin
                        grant_next = last_reg ? 2'b01 : 2'b10;
                    end else begin
                        grant_next = m0_wb_stb_i ? 2'b01 : 2'b10;
                    end
                end
            end
            BUSY: begin
                if (!g_stb) begin
                    state_next = IDLE;
                    grant_next = 2'b00;
                end else if (s_wb_ack_i || expire) begin
                    state_next = IDLE;
                    grant_next = 2'b00;
                    last_next  = sel;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

    assign s_wb_stb_o = busy & g_stb & ~expire;
    assign s_wb_we_o  = busy & g_we;
    assign s_wb_adr_o = busy ? g_adr : '0;
    assign s_wb_dat_o = busy ? g_dat : '0;
    assign grant_o    = grant_reg;

    // A forced termination acks the owner with zero data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign m_ack[gi] = (done_ack | expire) & grant_reg[gi];
        assign m_dat[gi] = (done_ack & grant_reg[gi]) ? s_wb_dat_i : '0;
    end

    assign m0_wb_ack_o = m_ack[0];
    assign m1_wb_ack_o = m_ack[1];
    assign m0_wb_dat_o = m_dat[0];
    assign m1_wb_dat_o = m_dat[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written
// reset/timeout sequences and a randomized run against a cycle model.
module tb_wb_arbiter;

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] grant;
        logic       s_stb;
        logic       s_we;
        logic [3:0] s_adr;
        logic [7:0] s_dat;
        logic       m0_ack;
        logic [7:0] m0_dat;
        logic       m1_ack;
        logic [7:0] m1_dat;
        logic       tout;
    } obs_t;

    typedef struct {
        logic       rst;
        logic       a_stb;
        logic       a_we;
        logic [3:0] a_adr;
        logic [7:0] a_dat;
        logic       b_stb;
        logic       b_we;
        logic [3:0] b_adr;
        logic [7:0] b_dat;
        logic       ack;
        logic [7:0] sdat;
        obs_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_we, m0_stb, m1_we, m1_stb;
    logic [3:0] m0_adr, m1_adr;
    logic [7:0] m0_dat, m1_dat;
    logic [7:0] m0_dat_o, m1_dat_o;
    logic       m0_ack_o, m1_ack_o;
    logic       s_we_o, s_stb_o;
    logic [3:0] s_adr_o;
    logic [7:0] s_dat_o;
    logic [7:0] s_dat_in;
    logic       s_ack;
    logic [1:0] grant;
    logic       tout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.AddrW(4), .DataW(8), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_wb_we_i(m0_we), .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat),
        .m0_wb_stb_i(m0_stb), .m0_wb_dat_o(m0_dat_o), .m0_wb_ack_o(m0_ack_o),
        .m1_wb_we_i(m1_we), .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat),
        .m1_wb_stb_i(m1_stb), .m1_wb_dat_o(m1_dat_o), .m1_wb_ack_o(m1_ack_o),
        .s_wb_we_o(s_we_o), .s_wb_adr_o(s_adr_o), .s_wb_dat_o(s_dat_o),
        .s_wb_stb_o(s_stb_o), .s_wb_dat_i(s_dat_in), .s_wb_ack_i(s_ack),
        .grant_o(grant), .timeout_o(tout)
    );

    function automatic obs_t ob(input logic [1:0] g, input logic st, input logic we,
                                input logic [3:0] ad, input logic [7:0] dt,
                                input logic a0, input logic [7:0] d0,
                                input logic a1, input logic [7:0] d1, input logic to);
        obs_t o;
        o = '{grant: g, s_stb: st, s_we: we, s_adr: ad, s_dat: dt,
              m0_ack: a0, m0_dat: d0, m1_ack: a1, m1_dat: d1, tout: to};
        return o;
    endfunction

    function automatic vec_t mk(input logic r,
                                input logic as, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                                input logic bs, input logic bw, input logic [3:0] ba, input logic [7:0] bd,
                                input logic k, input logic [7:0] sd, input obs_t e);
        vec_t v;
        v.rst = r;
        v.a_stb = as; v.a_we = aw; v.a_adr = aa; v.a_dat = ad;
        v.b_stb = bs; v.b_we = bw; v.b_adr = ba; v.b_dat = bd;
        v.ack = k; v.sdat = sd; v.exp = e;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input obs_t exp);
        obs_t act;
        #1;
        act = '{grant: grant, s_stb: s_stb_o, s_we: s_we_o, s_adr: s_adr_o, s_dat: s_dat_o,
                m0_ack: m0_ack_o, m0_dat: m0_dat_o, m1_ack: m1_ack_o, m1_dat: m1_dat_o,
                tout: tout};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        m0_we = 0; m0_stb = 0; m0_adr = 0; m0_dat = 0;
        m1_we = 0; m1_stb = 0; m1_adr = 0; m1_dat = 0;
        s_ack = 0; s_dat_in = 0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    // Cycle-level reference: owner -1 means bus free.
    task automatic rand_phase(input int cycles);
        int   owner, last, cnt;
        bit   tflag, s0, s1, st, tmo;
        obs_t e;
        reset_dut();
        owner = -1; last = 1; cnt = 0; tflag = 0; s0 = 0; s1 = 0;
        for (int c = 0; c < cycles; c++) begin
            if (!s0) begin m0_we = 1'($urandom); m0_adr = 4'($urandom); m0_dat = 8'($urandom); end
            if (!s1) begin m1_we = 1'($urandom); m1_adr = 4'($urandom); m1_dat = 8'($urandom); end
            m0_stb = s0; m1_stb = s1;
            s_ack = ($urandom % 3 == 0);
            s_dat_in = 8'($urandom);
            e = '0;
            e.tout = tflag;
            st = 0; tmo = 0;
            if (owner >= 0) begin
                e.grant = (owner == 1) ? 2'b10 : 2'b01;
                st      = (owner == 1) ? m1_stb : m0_stb;
                e.s_we  = (owner == 1) ? m1_we  : m0_we;
                e.s_adr = (owner == 1) ? m1_adr : m0_adr;
                e.s_dat = (owner == 1) ? m1_dat : m0_dat;
                tmo     = TO_EN && st && !s_ack && (cnt == TO - 1);
                e.s_stb = st && !tmo;
                if ((st && s_ack) || tmo) begin
                    if (owner == 1) begin e.m1_ack = 1; e.m1_dat = tmo ? 8'h00 : s_dat_in; end
                    else            begin e.m0_ack = 1; e.m0_dat = tmo ? 8'h00 : s_dat_in; end
                end
            end
            chk("rand", e);
            if (owner < 0) begin
                if (m0_stb || m1_stb) begin
                    owner = (m0_stb && m1_stb) ? 1 - last : (m0_stb ? 0 : 1);
                    cnt = 0;
                end
            end else if (!st) begin
                owner = -1;
            end else if (s_ack || tmo) begin
                last = owner;
                if (tmo) tflag = 1;
                owner = -1;
            end else begin
                cnt++;
            end
            s0 = e.m0_ack ? 1'($urandom) : (s0 ? ($urandom % 16 != 0) : ($urandom % 3 == 0));
            s1 = e.m1_ack ? 1'($urandom) : (s1 ? ($urandom % 16 != 0) : ($urandom % 3 == 0));
            step();
        end
    endtask

    vec_t tbl[17];
    obs_t z;

    initial begin
        z = ob(2'b00, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        // single write, then both-request ordering, then m1 read with m0 waiting
        tbl[0]  = mk(0, 1,1,4'h2,8'h5A, 0,0,4'h0,8'h00, 0,8'h00, z);
        tbl[1]  = mk(0, 1,1,4'h2,8'h5A, 0,0,4'h0,8'h00, 0,8'h00, ob(2'b01,1,1,4'h2,8'h5A,0,8'h00,0,8'h00,0));
        tbl[2]  = mk(0, 1,1,4'h2,8'h5A, 0,0,4'h0,8'h00, 1,8'h11, ob(2'b01,1,1,4'h2,8'h5A,1,8'h11,0,8'h00,0));
        tbl[3]  = mk(1, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,8'h00, z);
        tbl[4]  = mk(0, 1,0,4'h3,8'h00, 1,1,4'h7,8'h99, 0,8'h00, z);
        tbl[5]  = mk(0, 1,0,4'h3,8'h00, 1,1,4'h7,8'h99, 0,8'h00, ob(2'b01,1,0,4'h3,8'h00,0,8'h00,0,8'h00,0));
        tbl[6]  = mk(0, 1,0,4'h3,8'h00, 1,1,4'h7,8'h99, 1,8'h44, ob(2'b01,1,0,4'h3,8'h00,1,8'h44,0,8'h00,0));
        tbl[7]  = mk(0, 0,0,4'h0,8'h00, 1,1,4'h7,8'h99, 0,8'h00, z);
        tbl[8]  = mk(0, 0,0,4'h0,8'h00, 1,1,4'h7,8'h99, 0,8'h00, ob(2'b10,1,1,4'h7,8'h99,0,8'h00,0,8'h00,0));
        tbl[9]  = mk(0, 0,0,4'h0,8'h00, 1,1,4'h7,8'h99, 1,8'h55, ob(2'b10,1,1,4'h7,8'h99,0,8'h00,1,8'h55,0));
        tbl[10] = mk(0, 0,0,4'h0,8'h00, 1,0,4'h1,8'h00, 0,8'h00, z);
        tbl[11] = mk(0, 1,1,4'h4,8'h3C, 1,0,4'h1,8'h00, 0,8'h00, ob(2'b10,1,0,4'h1,8'h00,0,8'h00,0,8'h00,0));
        tbl[12] = mk(0, 1,1,4'h4,8'h3C, 1,0,4'h1,8'h00, 1,8'hC3, ob(2'b10,1,0,4'h1,8'h00,0,8'h00,1,8'hC3,0));
        tbl[13] = mk(0, 1,1,4'h4,8'h3C, 0,0,4'h0,8'h00, 0,8'h00, z);
        tbl[14] = mk(0, 1,1,4'h4,8'h3C, 0,0,4'h0,8'h00, 0,8'h00, ob(2'b01,1,1,4'h4,8'h3C,0,8'h00,0,8'h00,0));
        tbl[15] = mk(0, 1,1,4'h4,8'h3C, 0,0,4'h0,8'h00, 1,8'h21, ob(2'b01,1,1,4'h4,8'h3C,1,8'h21,0,8'h00,0));
        tbl[16] = mk(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00, 0,8'h00, z);

        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        chk("reset_state", z);
        step();

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst;
            m0_stb = tbl[i].a_stb; m0_we = tbl[i].a_we; m0_adr = tbl[i].a_adr; m0_dat = tbl[i].a_dat;
            m1_stb = tbl[i].b_stb; m1_we = tbl[i].b_we; m1_adr = tbl[i].b_adr; m1_dat = tbl[i].b_dat;
            s_ack = tbl[i].ack; s_dat_in = tbl[i].sdat;
            chk($sformatf("vec%0d", i), tbl[i].exp);
            step();
        end
        rst = 0;

        // reset in the middle of a transfer
        clear_inputs();
        m0_stb = 1; m0_adr = 4'h5;
        step();
        chk("rst_busy", ob(2'b01,1,0,4'h5,8'h00,0,8'h00,0,8'h00,0));
        rst = 1; m1_stb = 1; m1_adr = 4'h9;
        step();
        rst = 0; s_ack = 1; s_dat_in = 8'h66;
        chk("rst_after", z);
        step();
        chk("rst_tie", ob(2'b01,1,0,4'h5,8'h00,1,8'h66,0,8'h00,0));
        clear_inputs();
        step();
        chk("rst_done", z);

        rand_phase(400);

        reset_dut();
`ifdef WB_ARBITER_TIMEOUT_EN
        m0_stb = 1; m0_adr = 4'h6;
        m1_stb = 1; m1_we = 1; m1_adr = 4'h8; m1_dat = 8'hAB;
        s_dat_in = 8'h77;
        chk("to_idle", z);
        step();
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("to_wait%0d", k), ob(2'b01,1,0,4'h6,8'h00,0,8'h00,0,8'h00,0));
            step();
        end
        chk("to_fire", ob(2'b01,0,0,4'h6,8'h00,1,8'h00,0,8'h00,0));
        step();
        m0_stb = 0;
        chk("to_flag", ob(2'b00,0,0,4'h0,8'h00,0,8'h00,0,8'h00,1));
        step();
        s_ack = 1;
        chk("to_m1", ob(2'b10,1,1,4'h8,8'hAB,0,8'h00,1,8'h77,1));
        step();
        clear_inputs();
        chk("to_sticky", ob(2'b00,0,0,4'h0,8'h00,0,8'h00,0,8'h00,1));
`else
        m0_stb = 1; m0_adr = 4'h6;
        step();
        repeat (999) step();
        chk("no_timeout", ob(2'b01,1,0,4'h6,8'h00,0,8'h00,0,8'h00,0));
        m0_stb = 0;
        step();
        chk("abort_idle", z);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter AddrW, default 4, meaning Wishbone address width.
REQ-002 SHALL have parameter DataW, default 8, meaning Wishbone data width.
REQ-003 SHALL have parameter TimeoutCycles, default 255, meaning the cycles a granted transfer may wait for an ack before forced termination (range 2..65535).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports mN_wb_we_i, input, 1, the write enable from master N (N=0,1).
REQ-007 SHALL have ports mN_wb_adr_i, input, AddrW, the address from master N.
REQ-008 SHALL have ports mN_wb_dat_i, input, DataW, the write data from master N.
REQ-009 SHALL have ports mN_wb_stb_i, input, 1, the strobe from master N, held until ack.
REQ-010 SHALL have ports mN_wb_dat_o, output, DataW, the read data to master N.
REQ-011 SHALL have ports mN_wb_ack_o, output, 1, the ack to master N.
REQ-012 SHALL have ports s_wb_we_o, s_wb_adr_o and s_wb_dat_o, outputs, 1/AddrW/DataW, the shared-bus request toward the peripheral decoder.
REQ-013 SHALL have port s_wb_stb_o, output, 1, the shared-bus strobe.
REQ-014 SHALL have ports s_wb_dat_i and s_wb_ack_i, inputs, DataW/1, the shared-bus read data and ack.
REQ-015 SHALL have port grant_o, output, 2, one-hot owner of the shared bus (00 when idle).
REQ-016 SHALL have port timeout_o, output, 1, a sticky flag indicating a forced termination has occurred.

Function
REQ-017 SHALL implement the FSM states IDLE and BUSY, with a registered grant and a registered last-served bit.
REQ-018 In IDLE with any strobe high, SHALL pick the master per round-robin: the master not last served wins a tie; after reset m0 wins a tie.
REQ-019 The IDLE->BUSY transition SHALL take exactly 1 cycle; s_wb_stb_o SHALL be 0 in IDLE.
REQ-020 In BUSY, s_wb_we/adr/dat/stb_o SHALL equal the granted master's inputs combinationally.
REQ-021 In BUSY, s_wb_ack_i and s_wb_dat_i SHALL route combinationally to the granted master's ack_o/dat_o in the same cycle.
REQ-022 The non-granted master SHALL see ack_o=0 and dat_o=0 at all times.
REQ-023 When s_wb_ack_i=1 in BUSY, the FSM SHALL go to IDLE at the next edge and last-served SHALL be updated to the granted master.
REQ-024 When the granted master drops stb before ack (abort), the FSM SHALL go to IDLE without updating last-served, and a late ack SHALL be dropped.
REQ-025 The grant SHALL never change while in BUSY; requests from the other master SHALL wait.
REQ-026 With both masters continuously requesting, the grants SHALL alternate m0, m1, m0, ... with one IDLE cycle between transfers.
REQ-027 Outside BUSY, s_wb_we/adr/dat_o SHALL be 0.

Reset
REQ-028 With rst_i high at an edge, the state SHALL become IDLE, grant_o=00, last-served=m1 (so that m0 wins first), the timeout counter=0 and timeout_o=0.
REQ-029 A reset asserted mid-transfer SHALL abort the transfer; s_wb_stb_o and both mN_wb_ack_o SHALL be 0 from the cycle after the edge.

Configuration
REQ-030 With macro WB_ARBITER_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to BUSY and increment for each BUSY cycle without ack.
REQ-031 With WB_ARBITER_TIMEOUT_EN defined and the counter reaching TimeoutCycles-1, the block SHALL in that cycle drive s_wb_stb_o=0 and the granted mN_wb_ack_o=1 with mN_wb_dat_o=0, set timeout_o, and go to IDLE, with last-served updated.
REQ-032 An ack arriving in the same cycle as the timeout SHALL take precedence (real data returned, no flag).
REQ-033 With WB_ARBITER_TIMEOUT_EN undefined, there SHALL be no counter, BUSY SHALL wait indefinitely, and timeout_o SHALL be tied 0.

Verification
REQ-034 Reset, then m0 stb, we=1, adr=2, dat=0x5A, with the slave acking 2 cycles later -> grant_o=01 one cycle after stb, s_wb_* mirror m0, m0_ack_o pulses with the slave ack, then IDLE.
REQ-035 Both masters stb in the same cycle after reset, with the slave acking each after 1 cycle -> m0 served first, m1 second, with exactly one IDLE cycle between.
REQ-036 m1 read of adr=1 while m0 requests mid-transfer, with s_wb_dat_i=0xC3 -> m1_dat_o=0xC3 on ack, m0_ack_o stays 0, m0 granted next.
REQ-037 Reset asserted during BUSY -> s_wb_stb_o=0, grant_o=00 next cycle; first post-reset tie goes to m0.
REQ-038 With WB_ARBITER_TIMEOUT_EN and TimeoutCycles=4, slave never acks -> m0_ack_o=1 with dat 0 on the 4th BUSY cycle, timeout_o=1 sticky, m1 then served normally; with the macro undefined, the same stimulus -> still BUSY after 1000 cycles.
